// File: rtl/tt_sweep_capture.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tt_sweep_capture: sweeps a 3-input gate through all 8 rows and         |
// | captures its truth table (row 000 = MSB).  Rev 1.0 - initial release   |
// +------------------------------------------------------------------------+
module tt_sweep_capture #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         expected,
  output logic               in1,
  output logic               in2,
  output logic               in3,
  input  logic               gate_out,
  output logic               busy,
  output logic               done,
  output logic [7:0]         truth_table,
  output logic               match
);

  localparam int C_CNT_W = DWELL_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [1:0]           r_sync;
  logic                 w_gate_s;
  logic [DWELL_W-1:0]   r_dwell;
  logic [7:0]           r_expected;
  logic [2:0]           r_idx;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_prime;
  logic [7:0]           r_shadow;
  logic [7:0]           w_shadow_next;
  logic [C_CNT_W-1:0]   w_last;
  logic                 w_hold_end;
  logic                 w_last_row;

  assign w_gate_s = r_sync[1];

  // Last hold cycle index is D'+1, with a dwell of 0 treated as 1.
  assign w_last     = (r_dwell == '0) ? C_CNT_W'(2)
                                      : ({1'b0, r_dwell} + C_CNT_W'(1));
  assign w_hold_end = !r_prime && (r_cnt == w_last);
  assign w_last_row = (r_idx == 3'd7);

  always_comb begin
    w_shadow_next         = r_shadow;
    w_shadow_next[~r_idx] = w_gate_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = APPLY;
        end
      end
      APPLY: begin
        if (abort) begin
          w_state_next = IDLE;
        end else if (w_hold_end && w_last_row) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // The launch cycle after start (r_prime) keeps the sweep aligned so that
  // done lands one cycle after the last capture window closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= 2'b00;
      r_dwell     <= '0;
      r_expected  <= 8'h00;
      r_idx       <= 3'd0;
      r_cnt       <= '0;
      r_prime     <= 1'b0;
      r_shadow    <= 8'h00;
      truth_table <= 8'h00;
      match       <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], gate_out};
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dwell    <= dwell;
            r_expected <= expected;
            r_idx      <= 3'd0;
            r_cnt      <= '0;
            r_shadow   <= 8'h00;
            r_prime    <= 1'b1;
          end
        end
        APPLY: begin
          if (!abort) begin
            if (r_prime) begin
              r_prime <= 1'b0;
            end else if (w_hold_end) begin
              r_shadow <= w_shadow_next;
              r_cnt    <= '0;
              if (w_last_row) begin
                truth_table <= w_shadow_next;
                match       <= (w_shadow_next == r_expected);
              end else begin
                r_idx <= r_idx + 3'd1;
              end
            end else begin
              r_cnt <= r_cnt + C_CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign {in1, in2, in3} = (r_state == APPLY) ? r_idx : 3'b000;
  assign busy            = (r_state != IDLE);
  assign done            = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_capture.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_tt_sweep_capture: directed bench for tt_sweep_capture.              |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_tt_sweep_capture;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] dwell;
  logic [7:0] expected;
  logic       in1, in2, in3;
  logic       gate_out;
  logic       busy;
  logic       done;
  logic [7:0] truth_table;
  logic       match;
  logic [2:0] stim;

  int tests = 0;
  int fails = 0;

  tt_sweep_capture #(.DWELL_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .dwell       (dwell),
    .expected    (expected),
    .in1         (in1),
    .in2         (in2),
    .in3         (in3),
    .gate_out    (gate_out),
    .busy        (busy),
    .done        (done),
    .truth_table (truth_table),
    .match       (match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate under test: high for rows 100, 101, 111 -> truth table 8'h0D.
  assign stim     = {in1, in2, in3};
  assign gate_out = (stim == 3'b100) || (stim == 3'b101) || (stim == 3'b111);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stim"},  {29'd0, stim}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_tt"},    {24'd0, truth_table}, 32'h00);
    chk({tag, "_match"}, {31'd0, match}, 32'd0);
  endtask

  task automatic run_sweep(input logic [7:0] dw, input logic [7:0] ex, input int lat,
                           input logic [7:0] tt, input logic m, input bit hold_start);
    int         n;
    int         run;
    int         bad;
    int         nvec;
    int         dp;
    int         hold;
    logic [2:0] prev;
    hold     = ((dw == 8'd0) ? 1 : int'(dw)) + 2;
    dwell    = dw;
    expected = ex;
    start    = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    n    = 0;
    run  = 0;
    bad  = 0;
    nvec = 0;
    prev = 3'b000;
    while (!done && n < 600) begin
      tick();
      n++;
      if (stim != prev) begin
        if (prev != 3'b000) begin
          nvec++;
          if (run != hold) bad++;
        end
        run  = 1;
        prev = stim;
      end else begin
        run++;
      end
    end
    start = 1'b0;
    chk("latency", n, lat);
    chk("truth_table", {24'd0, truth_table}, {24'd0, tt});
    chk("match", {31'd0, match}, {31'd0, m});
    chk("bad_holds", bad, 0);
    chk("vectors_seen", nvec, 7);
    dp = 0;
    repeat (4) begin
      tick();
      if (done) dp++;
    end
    chk("extra_done", dp, 0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int dp;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    dwell    = 8'd0;
    expected = 8'h00;
    #3;
    chk_reset_outputs("por");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_sweep(8'd1, 8'h0D, 25, 8'h0D, 1'b1, 1'b0);
    run_sweep(8'd1, 8'h0E, 25, 8'h0D, 1'b0, 1'b0);
    run_sweep(8'd0, 8'h0D, 25, 8'h0D, 1'b1, 1'b0);
    run_sweep(8'd5, 8'h0D, 57, 8'h0D, 1'b1, 1'b0);

    // Abort while idle is a no-op.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", {31'd0, busy}, 32'd0);
    chk("idle_abort_tt", {24'd0, truth_table}, 32'h0D);

    // Abort at row 4 of a new sweep.
    dwell    = 8'd1;
    expected = 8'h0E;
    start    = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (stim != 3'b100 && n < 100) begin
      tick();
      n++;
    end
    chk("reach_row4", {29'd0, stim}, 32'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_stim", {29'd0, stim}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_tt", {24'd0, truth_table}, 32'h0D);
    chk("abort_match", {31'd0, match}, 32'd1);
    dp = 0;
    repeat (40) begin
      tick();
      if (done) dp++;
    end
    chk("abort_no_done", dp, 0);
    chk("abort_tt_late", {24'd0, truth_table}, 32'h0D);

    // Reset mid-sweep at row 3.
    dwell    = 8'd1;
    expected = 8'h0D;
    start    = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (stim != 3'b011 && n < 100) begin
      tick();
      n++;
    end
    chk("reach_row3", {29'd0, stim}, 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    run_sweep(8'd1, 8'h0D, 25, 8'h0D, 1'b1, 1'b0);

    // start held high throughout a sweep.
    run_sweep(8'd1, 8'h0D, 25, 8'h0D, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tt_sweep_capture.md
TT_SWEEP_CAPTURE -- requirements
Module: tt_sweep_capture

Interface
REQ-001 SHALL have parameter DWELL_W, default 8: width of the dwell-count input.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: single-cycle request to begin a sweep.
REQ-005 SHALL have port abort, input, 1 bit: cancels a sweep in progress.
REQ-006 SHALL have port dwell, input, DWELL_W bits: per-vector settle cycles, latched at start.
REQ-007 SHALL have port expected, input, 8 bits: golden truth-table word, latched at start.
REQ-008 SHALL have ports in1, in2, in3, output, 1 bit each: stimulus driven into the downstream 3-input gate (in1 = MSB).
REQ-009 SHALL have port gate_out, input, 1 bit: gate response, asynchronous to clk.
REQ-010 SHALL have port busy, output, 1 bit: high in APPLY and DONE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port truth_table, output, 8 bits: last completed capture.
REQ-013 SHALL have port match, output, 1 bit: truth_table equals the latched expected.

Function
REQ-014 SHALL implement states IDLE, APPLY, DONE.
REQ-015 SHALL pass gate_out through a 2-flop synchronizer before any use.
REQ-016 IDLE: start=1 SHALL latch dwell and expected, clear idx and the capture shadow, and enter APPLY next edge.
REQ-017 SHALL drive {in1,in2,in3} = idx (3-bit vector index, 0..7) in APPLY, and 3'b000 in IDLE and DONE.
REQ-018 Each vector SHALL be held for D'+2 cycles, where D' = max(latched dwell, 1); a dwell of 0 behaves as 1.
REQ-019 On the last hold cycle, the synchronized gate_out SHALL be written to shadow bit [7-idx]; row 000 is the MSB and row 111 the LSB (Cello hex convention).
REQ-020 After capture, idx<7 SHALL increment idx with the hold counter restarting; idx==7 SHALL enter DONE.
REQ-021 On the edge entering DONE, truth_table SHALL load the full shadow, including the final bit, and match SHALL load (shadow==expected).
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 Latency SHALL be: start sampled at edge T0 gives done=1 during the cycle following edge T0+8*(D'+2)+1.
REQ-024 start SHALL be ignored in APPLY and DONE.
REQ-025 abort=1 in APPLY SHALL return to IDLE next edge, with no done pulse, truth_table and match unchanged, and stimulus back to 000.
REQ-026 abort SHALL take priority over capture and over entry to DONE in the same cycle; abort in IDLE or DONE has no effect.
REQ-027 truth_table and match SHALL change only on entry to DONE.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE; in1..in3=0, busy=0, done=0, truth_table=8'h00, match=0; synchronizer, idx, counter and shadow cleared.
REQ-029 Reset asserted mid-sweep SHALL discard the partial capture; the first start after release begins a fresh sweep from idx 0.

Verification
REQ-030 Bench model gate_out = f({in1,in2,in3}), with f = 1 for rows 100, 101, 111; dwell=1, expected=8'h0D, start pulse -> done pulses 25 cycles after start, truth_table=8'h0D, match=1, and each vector is held exactly 3 cycles.
REQ-031 Same stimulus with expected=8'h0E -> truth_table=8'h0D, match=0.
REQ-032 dwell=0 and dwell=1 runs -> identical cycle timing and results; dwell=5 -> done 57 cycles after start.
REQ-033 Completed 0x0D sweep, then a new sweep aborted at idx=4 -> no done pulse, truth_table stays 8'h0D, in1..in3=000 next cycle, busy=0.
REQ-034 rst_n pulsed low at idx=3 -> all outputs at reset values immediately; a start after release produces a full 25-cycle sweep.
REQ-035 start reasserted every cycle during a sweep -> exactly one done pulse, with no restart or timing change.
